regfile_dump: RTL and testbench

Debug read-out engine on the read side of the SCCPU register file. On a start pulse it walks a range of register numbers on a spare regfile read port. It snapshots each 32-bit value and streams it as bytes over a valid/ready interface to the board UART/display path. It performs no writes; it is the reader counterpart to the regfile write port used by writeback.

---
 rtl/regfile_dump.sv | 183 ++++++++++++++++++
 tb/tb_regfile_dump.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//
// Debug read-out engine that sits on a spare read port of the SCCPU register
// file. A start pulse walks register numbers REG_LO..REG_HI. Each register is
// sampled once into a word register and then streamed as bytes, MSB first.
// When PREFIX_ADDR is set, each word is preceded by an address byte
// {3'b000, rn}. The engine never writes the register file.
//
// Ports
//   clk        system clock, all state on posedge
//   clrn       asynchronous active-low reset
//   start      one-cycle request to begin a dump (only honoured in IDLE)
//   abort      stop the dump at the next byte boundary (latched while busy)
//   rn         register number driven to the regfile read-address port
//   q          combinational regfile read data for rn
//   tx_data    byte presented to the consumer
//   tx_valid   tx_data is valid
//   tx_ready   consumer accepts the byte
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last byte of REG_HI is transferred
//   dbg_state  current FSM state (IDLE=0, READ=1, ADDR=2, SEND=3, DONE=4)
//
// Handshake: a byte moves when tx_valid & tx_ready at posedge. Once tx_valid
// is raised, tx_valid and tx_data hold until that transfer happens; tx_ready
// is ignored while tx_valid is low. Only reset can drop tx_valid early.
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int REG_LO      = 0,
    parameter int REG_HI      = 31,
    parameter int PREFIX_ADDR = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rn,
    input  logic [31:0] q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        ADDR = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [4:0] RN_LO = 5'(REG_LO);
    localparam logic [4:0] RN_HI = 5'(REG_HI);

    state_t      state;
    logic [1:0]  cnt;        // index of the data byte currently presented
    logic [31:0] word;       // the single snapshot of the current register
    logic        abort_q;    // abort seen earlier in this dump
    logic        abort_any;
    logic        xfer;

    assign abort_any = abort | abort_q;
    assign xfer      = tx_valid & tx_ready;
    assign dbg_state = state;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] c);
        logic [7:0] b;
        case (c)
            2'd3:    b = w[31:24];
            2'd2:    b = w[23:16];
            2'd1:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            rn       <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            word     <= '0;
            abort_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            // Branches that return to IDLE clear the latch again below.
            if (busy && abort) begin
                abort_q <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    // start wins over a simultaneous abort: abort is only latched while busy.
                    if (start) begin
                        state <= READ;
                        rn    <= RN_LO;
                        busy  <= 1'b1;
                    end
                end

                READ: begin
                    if (abort_any) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        abort_q <= 1'b0;
                    end else begin
                        word     <= q;
                        tx_valid <= 1'b1;
                        if (PREFIX_ADDR != 0) begin
                            state   <= ADDR;
                            tx_data <= {3'b000, rn};
                        end else begin
                            state   <= SEND;
                            cnt     <= 2'd3;
                            // word is not loaded yet, so take the first byte straight from q.
                            tx_data <= q[31:24];
                        end
                    end
                end

                ADDR: begin
                    if (xfer) begin
                        if (abort_any) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            abort_q  <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                        end else begin
                            state   <= SEND;
                            cnt     <= 2'd3;
                            tx_data <= word[31:24];
                        end
                    end
                end

                SEND: begin
                    if (xfer) begin
                        if (abort_any) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            abort_q  <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                        end else if (cnt != 2'd0) begin
                            cnt     <= cnt - 2'd1;
                            tx_data <= byte_of(word, cnt - 2'd1);
                        end else begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            // rn only advances below REG_HI, so it can never wrap.
                            if (rn >= RN_HI) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= READ;
                                rn    <= rn + 5'd1;
                            end
                        end
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    abort_q <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
//
// Bench for regfile_dump. Two instances are used:
//   u_dut  : REG_LO=0, REG_HI=31, PREFIX_ADDR=1
//   u_dut1 : REG_LO=REG_HI=9, PREFIX_ADDR=0
// A register-file array drives q for each instance. Expected bytes are pushed
// into a queue when a dump is requested. A negedge monitor pops one entry for
// every transfer, checks stall stability, and records done pulses.
// -----------------------------------------------------------------------------
module tb_regfile_dump;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0
    logic        clrn, start, abort, tx_ready;
    logic [4:0]  rn;
    logic [31:0] q;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;
    logic [2:0]  dbg_state;

    // instance 1
    logic        start1;
    logic        abort1   = 1'b0;
    logic        tx_ready1 = 1'b1;
    logic [4:0]  rn1;
    logic [31:0] q1;
    logic [7:0]  tx_data1;
    logic        tx_valid1, busy1, done1;
    logic [2:0]  dbg_state1;

    logic [31:0] rf [32];
    assign q  = (rn  == 5'd0) ? 32'd0 : rf[rn];
    assign q1 = (rn1 == 5'd0) ? 32'd0 : rf[rn1];

    regfile_dump #(.REG_LO(0), .REG_HI(31), .PREFIX_ADDR(1)) u_dut (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort), .rn(rn), .q(q),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    regfile_dump #(.REG_LO(9), .REG_HI(9), .PREFIX_ADDR(0)) u_dut1 (
        .clk(clk), .clrn(clrn), .start(start1), .abort(abort1), .rn(rn1), .q(q1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1), .dbg_state(dbg_state1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard / monitors ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];
    int         xfer_cnt = 0, done_cnt = 0, done_cyc = -1, start_cyc = 0;
    int         done1_cnt = 0, done1_cyc = -1, start1_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_byte, exp1_byte;

    always @(negedge clk) begin
        if (prev_stall) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_byte: got %02h with nothing expected", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                check("byte", 32'(tx_data), 32'(exp_byte));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc - start_cyc;
        end
    end

    always @(negedge clk) begin
        if (tx_valid1 && tx_ready1) begin
            if (exp1_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_byte1: got %02h with nothing expected", tx_data1);
            end else begin
                exp1_byte = exp1_q.pop_front();
                check("byte1", 32'(tx_data1), 32'(exp1_byte));
            end
        end
        if (done1) begin
            done1_cnt++;
            done1_cyc = cyc - start1_cyc;
        end
    end

    // ---------------- driver tasks ----------------
    logic [3:0] pat = 4'b1001;   // tx_ready sequence 1,0,0,1 (bit 0 first)
    int         bp_idx = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        while (cyc - start_cyc < n) tick();
    endtask

    task automatic wait_idle(input bit bp, output int idle_at);
        int budget = 600;
        idle_at = -1;
        while (budget > 0) begin
            tick();
            if (bp && tx_valid && rn == 5'd5) begin
                tx_ready = pat[bp_idx % 4];
                bp_idx++;
            end else begin
                tx_ready = 1'b1;
            end
            if (!busy) begin
                idle_at = cyc - start_cyc;
                break;
            end
            budget--;
        end
        if (idle_at < 0) begin
            n_checks++;
            $display("FAIL idle_timeout: busy still 1 after 600 cycles");
        end
    endtask

    function automatic void push_dump(input int lo, input int hi);
        logic [31:0] w;
        for (int r = lo; r <= hi; r++) begin
            w = (r == 0) ? 32'd0 : rf[r[4:0]];
            exp_q.push_back(8'(r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        end
    endfunction

    task automatic end_checks(input string tag, input int exp_done, input int exp_idle,
                              input int idle_at, input int done_before);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({tag, "_done_count"}, 32'(done_cnt), 32'(done_before + 1));
        check({tag, "_idle_cycle"}, 32'(idle_at), 32'(exp_idle));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rn_hold"}, 32'(rn), 32'd31);
    endtask

    // ---------------- main sequence ----------------
    int idle_at, done_before, idle1;

    initial begin
        clrn = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1; start1 = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = (i >= 1 && i <= 9) ? 32'(i) : 32'd0;

        // reset state
        #1 clrn = 1'b0;
        #2;
        check("rst_rn", 32'(rn), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        tick(); tick();
        clrn = 1'b1;
        tick();

        // 1: full dump, tx_ready held high
        xfer_cnt = 0; done_before = done_cnt;
        push_dump(0, 31);
        start_dump();
        wait_idle(1'b0, idle_at);
        end_checks("t1", 193, 194, idle_at, done_before);
        check("t1_xfer_count", 32'(xfer_cnt), 32'd160);

        // 2: back-pressure 1,0,0,1 while r5 is on the wire -> 4 extra cycles
        done_before = done_cnt; bp_idx = 0;
        push_dump(0, 31);
        start_dump();
        wait_idle(1'b1, idle_at);
        end_checks("t2", 197, 198, idle_at, done_before);

        // 3: regfile write after the READ of r3 must not leak into its bytes
        done_before = done_cnt;
        push_dump(0, 31);
        start_dump();
        wait_cycle(20);
        rf[3] = 32'hDEAD_BEEF;
        wait_idle(1'b0, idle_at);
        end_checks("t3a", 193, 194, idle_at, done_before);
        done_before = done_cnt;
        push_dump(0, 2);
        exp_q.push_back(8'h03); exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        push_dump(4, 31);
        start_dump();
        wait_idle(1'b0, idle_at);
        end_checks("t3b", 193, 194, idle_at, done_before);
        rf[3] = 32'd3;

        // 4: abort during a stalled 2nd data byte of r2, start while busy ignored
        done_before = done_cnt;
        push_dump(0, 1);
        exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        start_dump();
        wait_cycle(16);
        tx_ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; tx_ready = 1'b1;
        tick();
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_valid_after", 32'(tx_valid), 32'd0);
        check("t4_state_after", 32'(dbg_state), 32'd0);
        repeat (10) tick();
        check("t4_still_idle", 32'(busy), 32'd0);
        check("t4_no_done", 32'(done_cnt), 32'(done_before));
        check("t4_queue_left", 32'(exp_q.size()), 32'd0);

        // 5: reset in the middle of r7's data bytes
        done_before = done_cnt;
        push_dump(0, 6);
        exp_q.push_back(8'h07); exp_q.push_back(8'h00);
        start_dump();
        wait_cycle(46);
        clrn = 1'b0;
        #1;
        check("t5_async_rn", 32'(rn), 32'd0);
        check("t5_async_valid", 32'(tx_valid), 32'd0);
        check("t5_async_data", 32'(tx_data), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_queue_left", 32'(exp_q.size()), 32'd0);
        tick();
        clrn = 1'b1;
        tick();
        check("t5_no_done", 32'(done_cnt), 32'(done_before));
        push_dump(0, 31);
        start_dump();
        wait_idle(1'b0, idle_at);
        end_checks("t5", 193, 194, idle_at, done_before);

        // 6: single register, no address prefix
        exp1_q.push_back(8'h00); exp1_q.push_back(8'h00);
        exp1_q.push_back(8'h00); exp1_q.push_back(8'h09);
        start1 = 1'b1; start1_cyc = cyc;
        tick();
        start1 = 1'b0;
        idle1 = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!busy1) begin
                idle1 = cyc - start1_cyc;
                break;
            end
        end
        check("t6_done_cycle", 32'(done1_cyc), 32'd6);
        check("t6_done_count", 32'(done1_cnt), 32'd1);
        check("t6_idle_cycle", 32'(idle1), 32'd7);
        check("t6_queue_left", 32'(exp1_q.size()), 32'd0);
        check("t6_rn_hold", 32'(rn1), 32'd9);
        check("t6_state", 32'(dbg_state1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
